tech74_counter_163: RTL and testbench
=====================================

# tech74_counter_163

Synchronous binary counter cell modelling a cascade of 74x163-style 4-bit counter packages, used as the register stage downstream of the mapped 74x32 OR gates: decoded OR terms drive its enable, load and clear inputs. It provides the simulation model and techmap target for counter inference. Behaviour is cycle-exact to the chip, with a global reset added. WIDTH bits are built from WIDTH/4 slices chained through ripple-carry enables.

## Interface
- WIDTH, 4, counter width in bits; must be a positive multiple of 4, otherwise elaboration fails via a generate-time error.
- CLK  input  1  rising-edge clock; the only clock.
- RST  input  1  reset, synchronous and active-high; forces Q to 0.
- CLR_N  input  1  chip clear pin, synchronous, active-low.
- LOAD_N  input  1  parallel load, synchronous, active-low.
- ENP  input  1  count enable P (parallel enable).
- ENT  input  1  count enable T (trickle enable); also gates RCO.
- D  input  WIDTH  parallel load data.
- DIR  input  1  count direction, 1 = up, 0 = down; present only with TECH74_UPDOWN_EN.
- Q  output  WIDTH  counter value; reset value 0.
- RCO  output  1  ripple-carry out of the top slice.

## Operation
- Next-state priority at each CLK rising edge, highest first:
  - RST=1: Q <= 0.
  - CLR_N=0: Q <= 0.
  - LOAD_N=0: Q <= D. Load ignores ENP and ENT.
  - ENP=1 and ENT=1: Q <= Q+1 mod 2^WIDTH. With down-count, Q <= Q-1 mod 2^WIDTH.
  - Otherwise: Q holds.
- Slice structure: slice k holds Q[4k+3:4k].
  - Slice 0 ENT = port ENT; slice k ENT = RCO of slice k-1.
  - ENP, CLR_N, LOAD_N and RST are common to all slices.
- Slice RCO:
  - Up: ENT_k and (slice Q == 4'hF).
  - Down: ENT_k and (slice Q == 4'h0).
- Port RCO is the RCO of the top slice.
  - Equivalent: ENT and every slice at its terminal value.
  - Port RCO does not depend on ENP.
- Wrap-around:
  - Up: all ones -> 0.
  - Down: 0 -> all ones.
  - No saturation and no sticky flag.

## Timing
- Q is registered; one CLK of latency from any control or D change to Q.
- RCO is combinational from Q, ENT and DIR; it is valid in the same cycle. There is no registered path.
- RST, CLR_N and LOAD_N act only at the clock edge; none is asynchronous.
- Reset value of outputs after RST: Q = 0.
  - RCO = 0 in up mode.
  - RCO = ENT in down mode, because Q=0 is terminal.
- Simultaneous events:
  - RST wins over everything.
  - CLR_N=0 with LOAD_N=0: clear wins.
  - LOAD_N=0 with both enables high: load wins, no increment.
- Reset mid-count: the next edge yields Q=0 regardless of ENP/ENT. Counting resumes on the first edge after RST falls.
- DIR change mid-count takes effect at the next edge. RCO re-evaluates immediately.

## Configuration
- TECH74_UPDOWN_EN defined:
  - DIR port exists and each slice models a 74x169-style up/down counter.
  - Down count and down-mode RCO apply when DIR=0.
- TECH74_UPDOWN_EN undefined:
  - No DIR port.
  - Count is up only.
  - RCO uses the all-ones terminal.

## Test plan
- Reset and hold:
  - RST=1 for 2 cycles with ENP=ENT=1 -> Q=0, RCO=0.
  - Release RST, then ENP=0 for 3 cycles -> Q stays 0.
- Count and wrap, WIDTH=8, ENP=ENT=1, starting from load D=8'hFD:
  - Q goes FD, FE, FF, 00.
  - RCO=1 only while Q=FF.
  - Slice 1 advances only on the slice-0 0xF->0x0 edge.
- Priority, with CLR_N=0, LOAD_N=0, D=8'h5A, ENP=ENT=1:
  - -> Q=0.
  - Then CLR_N=1 -> Q=5A next edge, with no increment in that cycle.
- ENT gating: Q=8'hFF, ENT=0, ENP=1 -> Q holds FF and RCO=0. Set ENT=1 -> RCO=1 immediately, Q=00 next edge.
- Reset mid-operation: count to 8'h37, assert RST for one edge together with LOAD_N=0, D=8'hAA -> Q=0, then counting resumes at 01.
- With TECH74_UPDOWN_EN, DIR=0, Q=8'h01, ENP=ENT=1:
  - -> 00, then FF.
  - RCO=1 only at Q=00.
  - DIR=1 at Q=FF -> RCO=1 and Q=00 next edge.

Source files
------------

// File: rtl/tech74_counter_163.sv
// tech74_counter_163: cascade of 74x163-style 4-bit synchronous counter slices with ripple-carry enables.
// Define TECH74_UPDOWN_EN to add the DIR port and turn each slice into a 74x169-style up/down counter.
module tech74_counter_163 #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR_N,
  input  logic             LOAD_N,
  input  logic             ENP,
  input  logic             ENT,
  input  logic [WIDTH-1:0] D,
`ifdef TECH74_UPDOWN_EN
  input  logic             DIR,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);
  localparam int N = WIDTH / 4;
  if (WIDTH <= 0 || WIDTH % 4 != 0) begin : g_bad_width
    $error("tech74_counter_163: WIDTH must be a positive multiple of 4");
  end
  logic         w_up;
  logic [N:0]   w_ent;
`ifdef TECH74_UPDOWN_EN
  assign w_up = DIR;
`else
  assign w_up = 1'b1;
`endif
  assign w_ent[0] = ENT;
  for (genvar k = 0; k < N; k++) begin : g_slice
    logic [3:0] r_q;
    always_ff @(posedge CLK) begin
      if (RST || !CLR_N) r_q <= '0;
      else if (!LOAD_N) r_q <= D[4*k +: 4];
      else if (ENP && w_ent[k]) r_q <= w_up ? r_q + 4'd1 : r_q - 4'd1;
    end
    // trickle enable into the next slice is this slice's RCO
    assign w_ent[k+1] = w_ent[k] && (r_q == (w_up ? 4'hF : 4'h0));
    assign Q[4*k +: 4] = r_q;
  end
  assign RCO = w_ent[N];
endmodule

// File: tb/tb_tech74_counter_163.sv
// tb_tech74_counter_163: vector table, corner sequences and randomized run against an arithmetic model (WIDTH=8).
module tb_tech74_counter_163;
  logic       clk = 1'b0;
  logic       rst, clr_n, load_n, enp, ent;
  logic [7:0] d;
  logic       dir;
  logic [7:0] q;
  logic       rco;
  int         total = 0;
  int         bad = 0;
  logic [7:0] m_q;
  always #5 clk = ~clk;
  tech74_counter_163 #(.WIDTH(8)) dut (
    .CLK(clk), .RST(rst), .CLR_N(clr_n), .LOAD_N(load_n), .ENP(enp), .ENT(ent), .D(d),
`ifdef TECH74_UPDOWN_EN
    .DIR(dir),
`endif
    .Q(q), .RCO(rco)
  );
  typedef struct {
    logic       rst, clr_n, load_n, enp, ent;
    logic [7:0] d;
    logic [7:0] q;
    logic       rco;
    string      name;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, c, l, p, t, input logic [7:0] dd);
    @(negedge clk);
    rst = r; clr_n = c; load_n = l; enp = p; ent = t; d = dd;
  endtask
  task automatic add(input logic r, c, l, p, t, input logic [7:0] dd, input logic [7:0] eq,
                     input logic er, input string nm);
    vec_t v;
    v.rst = r; v.clr_n = c; v.load_n = l; v.enp = p; v.ent = t; v.d = dd;
    v.q = eq; v.rco = er; v.name = nm;
    tbl.push_back(v);
  endtask
  function automatic logic [7:0] model_next(input logic [7:0] cur, input logic r, c, l, p, t,
                                            input logic [7:0] dd, input logic up);
    if (r || !c) return 8'h00;
    if (!l) return dd;
    if (p && t) return up ? cur + 8'd1 : cur - 8'd1;
    return cur;
  endfunction
  initial begin
    rst = 1'b1; clr_n = 1'b1; load_n = 1'b1; enp = 1'b1; ent = 1'b1; d = 8'h00; dir = 1'b1;
    add(1, 1, 1, 1, 1, 8'h00, 8'h00, 0, "reset1");
    add(1, 1, 1, 1, 1, 8'h00, 8'h00, 0, "reset2");
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 1, 8'h00, 8'h00, 0, "hold_enp0");
    add(0, 1, 0, 1, 1, 8'hFD, 8'hFD, 0, "load_fd");
    add(0, 1, 1, 1, 1, 8'h00, 8'hFE, 0, "count_fe");
    add(0, 1, 1, 1, 1, 8'h00, 8'hFF, 1, "count_ff");
    add(0, 1, 1, 1, 1, 8'h00, 8'h00, 0, "wrap_00");
    add(0, 1, 0, 1, 1, 8'h0E, 8'h0E, 0, "load_0e");
    add(0, 1, 1, 1, 1, 8'h00, 8'h0F, 0, "count_0f");
    add(0, 1, 1, 1, 1, 8'h00, 8'h10, 0, "slice_carry");
    add(0, 1, 1, 1, 1, 8'h00, 8'h11, 0, "count_11");
    add(0, 0, 0, 1, 1, 8'h5A, 8'h00, 0, "clr_over_load");
    add(0, 1, 0, 1, 1, 8'h5A, 8'h5A, 0, "load_no_inc");
    add(0, 1, 1, 1, 0, 8'h00, 8'h5A, 0, "hold_ent0");
    add(0, 1, 0, 0, 0, 8'hFF, 8'hFF, 0, "load_ignores_en");
    add(0, 1, 1, 1, 0, 8'h00, 8'hFF, 0, "ent0_ff_hold");
    add(0, 1, 0, 1, 1, 8'h36, 8'h36, 0, "load_36");
    add(0, 1, 1, 1, 1, 8'h00, 8'h37, 0, "count_37");
    add(1, 1, 0, 1, 1, 8'hAA, 8'h00, 0, "rst_over_load");
    add(0, 1, 1, 1, 1, 8'h00, 8'h01, 0, "resume_01");
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].clr_n, tbl[i].load_n, tbl[i].enp, tbl[i].ent, tbl[i].d);
      @(posedge clk); #1;
      chk({tbl[i].name, "_q"}, q, tbl[i].q);
      chk({tbl[i].name, "_rco"}, {7'd0, rco}, {7'd0, tbl[i].rco});
    end
    // ENT gating: RCO follows ENT combinationally at Q=FF, then count wraps
    drive(0, 1, 0, 1, 1, 8'hFF);
    drive(0, 1, 1, 1, 0, 8'h00);
    #1 chk("gate_rco_low", {7'd0, rco}, 8'd0);
    drive(0, 1, 1, 1, 1, 8'h00);
    #1 chk("gate_rco_imm", {7'd0, rco}, 8'd1);
    @(posedge clk); #1;
    chk("gate_wrap_q", q, 8'h00);
`ifdef TECH74_UPDOWN_EN
    drive(0, 1, 0, 1, 1, 8'h01);
    dir = 1'b0;
    @(posedge clk); #1;
    chk("dn_load_q", q, 8'h01);
    chk("dn_load_rco", {7'd0, rco}, 8'd0);
    drive(0, 1, 1, 1, 1, 8'h00);
    @(posedge clk); #1;
    chk("dn_00_q", q, 8'h00);
    chk("dn_00_rco", {7'd0, rco}, 8'd1);
    @(posedge clk); #1;
    chk("dn_ff_q", q, 8'hFF);
    chk("dn_ff_rco", {7'd0, rco}, 8'd0);
    @(negedge clk);
    dir = 1'b1;
    #1 chk("dir_up_rco", {7'd0, rco}, 8'd1);
    @(posedge clk); #1;
    chk("dir_up_q", q, 8'h00);
`endif
    // randomized run against the arithmetic model
    drive(1, 1, 1, 1, 1, 8'h00);
    @(posedge clk); #1;
    m_q = 8'h00;
    for (int i = 0; i < 400; i++) begin
      logic r, c, l, p, t, up;
      logic [7:0] dd;
      r = ($urandom_range(31) == 0);
      c = ($urandom_range(15) != 0);
      l = ($urandom_range(7) != 0);
      p = ($urandom_range(5) != 0);
      t = ($urandom_range(5) != 0);
      dd = 8'($urandom);
      if ($urandom_range(3) == 0) dd = ($urandom_range(1) == 0) ? 8'hFE : 8'h01;
      drive(r, c, l, p, t, dd);
`ifdef TECH74_UPDOWN_EN
      dir = ($urandom_range(3) != 0);
      up = dir;
`else
      up = 1'b1;
`endif
      m_q = model_next(m_q, r, c, l, p, t, dd, up);
      @(posedge clk); #1;
      chk("rand_q", q, m_q);
      chk("rand_rco", {7'd0, rco}, {7'd0, t && (m_q == (up ? 8'hFF : 8'h00))});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
